// File: rtl/cook_timer_sequencer_if.sv
// Keypad/timer bundle between the microwave front panel datapath and the cook timer sequencer.
// The master side drives the keypad, buttons, door and 1 Hz inputs; the slave side returns time digits and status.
interface cook_timer_sequencer_if;
  logic [3:0] D;
  logic       loadn;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic       pgt_1Hz;
  logic       enablen;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       magnetron_on;
  logic       done;
  logic [2:0] state;

  modport master (
    output D, loadn, startn, stopn, door_closed, pgt_1Hz,
    input  enablen, min_tens, min_ones, sec_tens, sec_ones, magnetron_on, done, state
  );

  modport slave (
    input  D, loadn, startn, stopn, door_closed, pgt_1Hz,
    output enablen, min_tens, min_ones, sec_tens, sec_ones, magnetron_on, done, state
  );
endinterface

// File: rtl/cook_timer_sequencer.sv
// Microwave cook timer: shifts keypad digits into an MM:SS BCD register, counts it down at 1 Hz
// while heating, and handles pause, door open, stop/clear and the timed completion indication.
module cook_timer_sequencer #(
  parameter int DONE_SECONDS = 3
) (
  input  logic                     clock_100Hz,
  input  logic                     clearn,
  cook_timer_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CW = $clog2(DONE_SECONDS + 1);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_SECONDS - 1);

  state_t        state_reg, state_next;
  logic [3:0]    mt_reg, mo_reg, st_reg, so_reg;
  logic [3:0]    mt_next, mo_next, st_next, so_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          loadn_q, startn_q, stopn_q, tick_q;
  logic          magnetron_on_reg, done_reg, enablen_reg;

  logic key_ev, start_ev, stop_ev, tick_ev;
  logic time_zero, dec_zero;
  logic b0, b1, b2;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;

  assign key_ev   = loadn_q & ~bus.loadn;
  assign start_ev = startn_q & ~bus.startn;
  assign stop_ev  = stopn_q & ~bus.stopn;
  assign tick_ev  = ~tick_q & bus.pgt_1Hz;

  assign time_zero = (mt_reg == 4'd0) && (mo_reg == 4'd0) && (st_reg == 4'd0) && (so_reg == 4'd0);

  // Borrow chain; seconds tens wraps to 5 so entries like 0:90 fall naturally into 0:59.
  assign b0     = (so_reg == 4'd0);
  assign b1     = b0 && (st_reg == 4'd0);
  assign b2     = b1 && (mo_reg == 4'd0);
  assign dec_so = b0 ? 4'd9 : so_reg - 4'd1;
  assign dec_st = b0 ? ((st_reg == 4'd0) ? 4'd5 : st_reg - 4'd1) : st_reg;
  assign dec_mo = b1 ? ((mo_reg == 4'd0) ? 4'd9 : mo_reg - 4'd1) : mo_reg;
  assign dec_mt = b2 ? mt_reg - 4'd1 : mt_reg;
  assign dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) && (dec_st == 4'd0) && (dec_so == 4'd0);

  always_comb begin
    state_next = state_reg;
    mt_next    = mt_reg;
    mo_next    = mo_reg;
    st_next    = st_reg;
    so_next    = so_reg;
    cnt_next   = cnt_reg;
    // Each branch is an if/else chain so only the highest-priority event acts in a cycle.
    case (state_reg)
      IDLE, ENTRY: begin
        if (stop_ev) begin
          state_next = IDLE;
          mt_next = 4'd0; mo_next = 4'd0; st_next = 4'd0; so_next = 4'd0;
        end else if (start_ev && bus.door_closed && !time_zero) begin
          state_next = RUN;
        end else if (key_ev && (bus.D <= 4'd9)) begin
          state_next = ENTRY;
          mt_next = mo_reg;
          mo_next = st_reg;
          st_next = so_reg;
          so_next = bus.D;
        end
      end
      RUN: begin
        if (stop_ev || !bus.door_closed) begin
          state_next = PAUSE;
        end else if (tick_ev && !time_zero) begin
          mt_next = dec_mt;
          mo_next = dec_mo;
          st_next = dec_st;
          so_next = dec_so;
          if (dec_zero) begin
            state_next = DONE;
            cnt_next   = '0;
          end
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          state_next = IDLE;
          mt_next = 4'd0; mo_next = 4'd0; st_next = 4'd0; so_next = 4'd0;
        end else if (start_ev && bus.door_closed) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (stop_ev) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (tick_ev) begin
          if (cnt_reg == DONE_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        mt_next = 4'd0; mo_next = 4'd0; st_next = 4'd0; so_next = 4'd0;
        cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock_100Hz or negedge clearn) begin
    if (!clearn) begin
      state_reg        <= IDLE;
      mt_reg           <= 4'd0;
      mo_reg           <= 4'd0;
      st_reg           <= 4'd0;
      so_reg           <= 4'd0;
      cnt_reg          <= '0;
      loadn_q          <= 1'b1;
      startn_q         <= 1'b1;
      stopn_q          <= 1'b1;
      tick_q           <= 1'b0;
      magnetron_on_reg <= 1'b0;
      done_reg         <= 1'b0;
      enablen_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      mt_reg           <= mt_next;
      mo_reg           <= mo_next;
      st_reg           <= st_next;
      so_reg           <= so_next;
      cnt_reg          <= cnt_next;
      loadn_q          <= bus.loadn;
      startn_q         <= bus.startn;
      stopn_q          <= bus.stopn;
      tick_q           <= bus.pgt_1Hz;
      // Status flags follow the new state on the same edge.
      magnetron_on_reg <= (state_next == RUN);
      done_reg         <= (state_next == DONE);
      enablen_reg      <= !((state_next == IDLE) || (state_next == ENTRY));
    end
  end

  assign bus.state        = state_reg;
  assign bus.min_tens     = mt_reg;
  assign bus.min_ones     = mo_reg;
  assign bus.sec_tens     = st_reg;
  assign bus.sec_ones     = so_reg;
  assign bus.magnetron_on = magnetron_on_reg;
  assign bus.done         = done_reg;
  assign bus.enablen      = enablen_reg;

endmodule

// File: tb/tb_cook_timer_sequencer.sv
// Bench for cook_timer_sequencer: directed front-panel sequences plus random traffic, checked per clock
// against a time-in-minutes/seconds reference model through an expected-response queue.
module tb_cook_timer_sequencer;

  localparam int DONE_SECONDS = 3;

  logic clk;
  logic clearn;

  cook_timer_sequencer_if bus();

  cook_timer_sequencer #(.DONE_SECONDS(DONE_SECONDS)) dut (
    .clock_100Hz (clk),
    .clearn      (clearn),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int mt;
    int mo;
    int sx;
    int so;
    bit mag;
    bit dn;
    bit en;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: time held as whole minutes and seconds, digits derived by division.
  int m_state;
  int m_min, m_sec;
  int m_cnt;
  bit m_lq, m_sq, m_pq, m_tq;
  bit door, hz;

  task automatic push_expected();
    exp_t e;
    e.st  = m_state;
    e.mt  = m_min / 10;
    e.mo  = m_min % 10;
    e.sx  = m_sec / 10;
    e.so  = m_sec % 10;
    e.mag = (m_state == 2);
    e.dn  = (m_state == 4);
    e.en  = !(m_state == 0 || m_state == 1);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_state = 0; m_min = 0; m_sec = 0; m_cnt = 0;
    m_lq = 1; m_sq = 1; m_pq = 1; m_tq = 0;
    push_expected();
  endtask

  task automatic model_step(input int d, input bit ld, input bit st, input bit sp, input bit dr, input bit h);
    bit key_ev, start_ev, stop_ev, tick_ev, zero;
    key_ev   = m_lq && !ld;
    start_ev = m_sq && !st;
    stop_ev  = m_pq && !sp;
    tick_ev  = !m_tq && h;
    m_lq = ld; m_sq = st; m_pq = sp; m_tq = h;
    zero = (m_min == 0) && (m_sec == 0);
    case (m_state)
      0, 1: begin
        if (stop_ev) begin
          m_state = 0; m_min = 0; m_sec = 0;
        end else if (start_ev && dr && !zero) begin
          m_state = 2;
        end else if (key_ev && d <= 9) begin
          // Appending a digit: MMSS*10 + d, keeping the last four digits.
          int v;
          v = ((m_min * 100 + m_sec) * 10 + d) % 10000;
          m_min = v / 100;
          m_sec = v % 100;
          m_state = 1;
        end
      end
      2: begin
        if (stop_ev || !dr) begin
          m_state = 3;
        end else if (tick_ev && !zero) begin
          if (m_sec > 0) m_sec = m_sec - 1;
          else begin
            m_min = m_min - 1;
            m_sec = 59;
          end
          if (m_min == 0 && m_sec == 0) begin
            m_state = 4;
            m_cnt = 0;
          end
        end
      end
      3: begin
        if (stop_ev) begin
          m_state = 0; m_min = 0; m_sec = 0;
        end else if (start_ev && dr) begin
          m_state = 2;
        end
      end
      default: begin
        if (stop_ev) begin
          m_state = 0; m_min = 0; m_sec = 0;
        end else if (tick_ev) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == DONE_SECONDS) m_state = 0;
        end
      end
    endcase
    push_expected();
  endtask

  task automatic step(input int d, input bit ld, input bit st, input bit sp);
    @(negedge clk);
    clearn          = 1'b1;
    bus.D           = 4'(d);
    bus.loadn       = ld;
    bus.startn      = st;
    bus.stopn       = sp;
    bus.door_closed = door;
    bus.pgt_1Hz     = hz;
    model_step(d, ld, st, sp, door, hz);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 1);
  endtask

  task automatic key(input int d);
    step(d, 0, 1, 1);
    step(d, 1, 1, 1);
  endtask

  task automatic press_start();
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
  endtask

  task automatic press_stop();
    step(0, 1, 1, 0);
    step(0, 1, 1, 1);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      hz = 1; step(0, 1, 1, 1); step(0, 1, 1, 1);
      hz = 0; step(0, 1, 1, 1); step(0, 1, 1, 1);
    end
  endtask

  // Pulls clearn low between clock edges; the monitor checks the outputs before the next edge.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    clearn = 1'b0;
    model_reset();
  endtask

  // Monitor: one comparison per clock (or per reset pulse) whenever an expectation is pending.
  initial begin
    forever begin
      @(posedge clk or negedge clearn);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (int'(bus.state) != e.st || int'(bus.min_tens) != e.mt || int'(bus.min_ones) != e.mo ||
            int'(bus.sec_tens) != e.sx || int'(bus.sec_ones) != e.so || bus.magnetron_on !== e.mag ||
            bus.done !== e.dn || bus.enablen !== e.en) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t: got state=%0d time=%0d%0d:%0d%0d mag=%b done=%b enablen=%b, required state=%0d time=%0d%0d:%0d%0d mag=%b done=%b enablen=%b",
                   vectors, $time, bus.state, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
                   bus.magnetron_on, bus.done, bus.enablen,
                   e.st, e.mt, e.mo, e.sx, e.so, e.mag, e.dn, e.en);
        end
      end
    end
  end

  initial begin
    int guard;
    clearn = 1'b1;
    door = 1; hz = 0;
    bus.D = 4'd0; bus.loadn = 1; bus.startn = 1; bus.stopn = 1;
    bus.door_closed = 1; bus.pgt_1Hz = 0;

    apply_reset();
    idle(2);

    // Keys 1,3,0, then a held key adds a single digit.
    key(1); key(3); key(0);
    idle(1);
    for (int i = 0; i < 50; i++) step(7, 0, 1, 1);
    idle(2);
    press_stop();

    // 0:05 runs to DONE, then DONE times out back to IDLE.
    key(0); key(5);
    press_start();
    tick(5);
    tick(3);
    idle(2);

    // 1:00 -> 0:59, and 0:90 counted through 0:60 to 0:59.
    key(1); key(0); key(0);
    press_start();
    tick(1);
    press_stop(); press_stop();
    key(9); key(0);
    press_start();
    tick(31);
    press_stop(); press_stop();

    // Door opened mid-run, start with door open, resume.
    key(1); key(0);
    press_start();
    door = 0; idle(2);
    tick(2);
    press_start();
    door = 1; idle(1);
    press_start();
    tick(2);
    press_stop(); press_stop();

    // Start at 0000, illegal key, stop+start together while running.
    press_start();
    key(12);
    key(3);
    press_start();
    step(0, 1, 0, 0);
    idle(2);
    press_stop();

    // Asynchronous clear mid-run at 0:42.
    key(4); key(2);
    press_start();
    idle(3);
    apply_reset();
    idle(3);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      int d;
      bit ld, st, sp;
      d  = int'($urandom_range(0, 15));
      ld = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 9) != 0);
      sp = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 40) == 0) door = ~door;
      if ($urandom_range(0, 2) == 0) hz = ~hz;
      if ($urandom_range(0, 600) == 0) apply_reset();
      step(d, ld, st, sp);
    end
    idle(2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cook_timer_sequencer.md
Name: cook_timer_sequencer

Overview:
Controller that sequences the keypad and 1 Hz timing datapath of the microwave. Keypad digits from the priority encoder (D, loadn) are shifted into a 4-digit BCD MM:SS register. On start, the register counts down on each 1 Hz edge while the magnetron is enabled. The block also handles pause, door-open, stop/clear and completion, and drives enablen back to the keypad/timer datapath.

Parameters:
DONE_SECONDS, 3, number of 1 Hz edges the done indication is held before returning to IDLE (1..15)

Ports:
clock_100Hz  input  1  system clock; all state changes on its rising edge
clearn  input  1  asynchronous active-low reset
D  input  4  encoded keypad digit, valid while loadn low
loadn  input  1  active-low key-valid from encoder
startn  input  1  active-low start button, synchronous level
stopn  input  1  active-low stop/clear button, synchronous level
door_closed  input  1  1 = door closed
pgt_1Hz  input  1  1 Hz square wave from the timer datapath, sampled as data
enablen  output  1  0 = keypad entry enabled (to datapath)
min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD time digits
magnetron_on  output  1  heating enable
done  output  1  cycle-complete indication
state  output  3  IDLE=0, ENTRY=1, RUN=2, PAUSE=3, DONE=4

Behaviour:
- Reset (clearn low, asynchronous): state IDLE, all digits 0, magnetron_on 0, done 0, enablen 0, edge registers cleared (loadn_q=1, startn_q=1, stopn_q=1, tick_q=0).
- Edge detection, one registered copy each:
  - key event = loadn_q & ~loadn
  - start event = startn_q & ~startn
  - stop event = stopn_q & ~stopn
  - tick = ~tick_q & pgt_1Hz
  - All events last one cycle. Holding a button gives exactly one event.
- Key event, accepted only in IDLE/ENTRY and only if D <= 9:
  - Shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
  - The digit shifted out of min_tens is lost.
  - IDLE -> ENTRY. D > 9 is ignored and the state does not change.
- Priority within one cycle: stop > door open > start > tick > key. Exactly one action per cycle. Lower-priority events in that cycle are dropped.
- Transitions:
  - IDLE/ENTRY + start, door_closed=1, time != 0000 -> RUN. Start with time 0000 or door open is ignored.
  - ENTRY + stop -> IDLE, digits cleared.
  - RUN + stop -> PAUSE, digits held.
  - RUN + door_closed=0 -> PAUSE.
  - RUN + tick -> decrement. If the result is 0000 -> DONE.
  - PAUSE + start with door_closed=1 -> RUN. Start with door open is ignored.
  - PAUSE + stop -> IDLE, digits cleared.
  - DONE: counts ticks. After DONE_SECONDS ticks -> IDLE. A stop event -> IDLE immediately.
- BCD decrement, per digit:
  - sec_ones 0 -> 9 with borrow, otherwise -1.
  - sec_tens 0 -> 5 with borrow.
  - min_ones 0 -> 9 with borrow.
  - min_tens -1.
  - A decrement is never applied at 0000.
  - Entered sec_tens > 5 is legal: 0:90 counts 0:89 ... 0:60, 0:59.
  - Digits beyond 9 are never produced.
- Registered outputs, updated in the same edge as the state:
  - magnetron_on = 1 only in RUN.
  - done = 1 only in DONE.
  - enablen = 0 in IDLE/ENTRY, otherwise 1.
- First decrement happens on the first tick edge after entering RUN. A tick in the same cycle as start is not applied.
- DONE tick counter: ceil(log2(DONE_SECONDS+1)) bits, cleared on entry to DONE.
- Reset mid-RUN drops everything to the reset values asynchronously. No partial state is kept.

Test Plan:
- Keys 1,3,0 (loadn pulses, D=1,3,0) -> digits 0,1,3,0, state ENTRY. Holding loadn low for 50 cycles adds only one digit.
- Entry 0:05, start with door closed -> RUN, magnetron_on=1, enablen=1. After 5 pgt_1Hz rising edges -> 0000, DONE, done=1. After 3 more edges -> IDLE, done=0.
- Entry 1:00, run 1 tick -> 0:59. Entry 0:90, 31 ticks -> 0:59, confirming borrow across digits.
- RUN at 0:10, door opened -> PAUSE, magnetron_on=0, ticks ignored. Start while door open -> stays PAUSE. Close door, start -> RUN, count resumes from 0:10.
- Start with time 0000 -> stays IDLE. Key D=12 -> ignored. Stop and start asserted in the same cycle while in RUN -> PAUSE.
- clearn pulsed low mid-RUN at 0:42 between clock edges -> outputs immediately 0000, IDLE, magnetron_on=0, enablen=0.
